// File: rtl/cpu_pkg.sv
// Shared CPU definitions: funct3 memory-width codes, exception causes
// and the load/store unit state encoding.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    // Halfwords need bit 0 clear; words (and any unlisted width,
    // which behaves as a word) need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = lo[0];
            default:     mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports: funct3_i/addr_lo_i select width and lane; wdata_i -> wdata_o
// replicated store data, be_o byte enables, rdata_i -> ldata_o extended
// load value, lane_o the naturally aligned low address bits.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [1:0]  lane_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [31:0] rsh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        rsh      = rdata_i >> {addr_lo_i, 3'b000};
        byte_sel = rsh[7:0];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        lane_o  = 2'b00;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        ldata_o = rdata_i;

        case (funct3_i)
            F3_B, F3_BU: begin
                lane_o  = addr_lo_i;
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                if (funct3_i == F3_B) begin
                    ldata_o = {{24{byte_sel[7]}}, byte_sel};
                end else begin
                    ldata_o = {24'b0, byte_sel};
                end
            end
            F3_H, F3_HU: begin
                lane_o  = {addr_lo_i[1], 1'b0};
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                if (funct3_i == F3_H) begin
                    ldata_o = {{16{half_sel[15]}}, half_sel};
                end else begin
                    ldata_o = {16'b0, half_sel};
                end
            end
            default: begin
                lane_o  = 2'b00;
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                ldata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: one outstanding access between execute and data memory.
// Execute side valid/ready (req_*), memory side req/ack (mem_*),
// load results to writeback (wb_*), completion/exception pulses
// (done, exc_valid, exc_cause). Sync active-high reset.
// Build option MISALIGN_TRAP_EN: misaligned H/W accesses trap (cause 4/6)
// instead of being silently aligned.
module cpu_lsu
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TMO_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        exc_valid,
    output logic [3:0]  exc_cause
);

    lsu_state_e state_q, state_d;

    logic             we_q,     we_d;
    logic             ld_q,     ld_d;
    logic [31:0]      addr_q,   addr_d;
    logic [3:0]       be_q,     be_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic [2:0]       f3_q,     f3_d;
    logic [1:0]       lo_q,     lo_d;
    logic [4:0]       rd_q,     rd_d;
    logic [31:0]      wbdata_q, wbdata_d;
    logic [3:0]       cause_q,  cause_d;
    logic             fault_q,  fault_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;

    logic        idle;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [1:0]  al_lane;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        tmo_hit;

    assign idle = (state_q == LSU_IDLE);

    // While idle the aligner sees the incoming request; during the
    // access it sees the latched width/lane so it can extend read data.
    assign al_f3 = idle ? req_funct3    : f3_q;
    assign al_lo = idle ? req_addr[1:0] : lo_q;

    lsu_align u_align (
        .funct3_i  (al_f3),
        .addr_lo_i (al_lo),
        .wdata_i   (req_wdata),
        .rdata_i   (mem_rdata),
        .lane_o    (al_lane),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ldata_o   (al_ldata)
    );

    assign tmo_hit = (TIMEOUT_CYC != 0) &&
                     ((32'(tmo_q) + 32'd1) == 32'(TIMEOUT_CYC));

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        ld_d     = ld_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        lo_d     = lo_q;
        rd_d     = rd_q;
        wbdata_d = wbdata_q;
        cause_d  = cause_q;
        fault_d  = fault_q;
        tmo_d    = tmo_q;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d    = req_store;
                    ld_d    = req_load;
                    addr_d  = {req_addr[31:2], 2'b00};
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    f3_d    = req_funct3;
                    lo_d    = al_lane;
                    rd_d    = req_rd;
                    fault_d = 1'b0;
                    tmo_d   = '0;
                    state_d = LSU_ACCESS;
`ifdef MISALIGN_TRAP_EN
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        fault_d = 1'b1;
                        cause_d = req_store ? CAUSE_ST_MISALIGN
                                            : CAUSE_LD_MISALIGN;
                        state_d = LSU_RESP;
                    end
`endif
                end
            end
            LSU_ACCESS: begin
                if (mem_ack) begin
                    if (ld_q) begin
                        wbdata_d = al_ldata;
                    end
                    tmo_d   = '0;
                    state_d = LSU_RESP;
                end else if (tmo_hit) begin
                    fault_d = 1'b1;
                    cause_d = we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    tmo_d   = '0;
                    state_d = LSU_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LSU_IDLE;
            we_q     <= 1'b0;
            ld_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            lo_q     <= '0;
            rd_q     <= '0;
            wbdata_q <= '0;
            cause_q  <= '0;
            fault_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            ld_q     <= ld_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            f3_q     <= f3_d;
            lo_q     <= lo_d;
            rd_q     <= rd_d;
            wbdata_q <= wbdata_d;
            cause_q  <= cause_d;
            fault_q  <= fault_d;
            tmo_q    <= tmo_d;
        end
    end

    assign req_ready = idle;
    assign mem_req   = (state_q == LSU_ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == LSU_RESP);
    assign wb_valid  = (state_q == LSU_RESP) && ld_q && !fault_q;
    assign exc_valid = (state_q == LSU_RESP) && fault_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wbdata_q;
    assign exc_cause = cause_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed self-checking bench for cpu_lsu.
// Define MISALIGN_TRAP_EN for both bench and RTL to exercise the trap build.
`timescale 1ns/1ps
module tb_cpu_lsu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, done, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  exc_cause;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_lsu dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .exc_valid(exc_valid), .exc_cause(exc_cause)
    );

    // Presents one request for a single accepting edge; returns #1 after it.
    task automatic drive_req(input logic ld, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [4:0] rd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = !ld;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || done !== 1'b0 || wb_valid !== 1'b0 ||
            exc_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctl: req=%b done=%b wb=%b exc=%b rdy=%b required 0 0 0 0 1",
                     mem_req, done, wb_valid, exc_valid, req_ready);
        end
        n_cmp++;
        if (mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem: we=%b be=%h addr=%h wd=%h required all zero",
                     mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_cmp++;
        if (wb_rd !== 5'd0 || wb_data !== 32'h0 || exc_cause !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_wb: rd=%0d data=%h cause=%0d required zero",
                     wb_rd, wb_data, exc_cause);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_byte();
        drive_req(1'b0, F3_B, 32'h0000_0103, 32'h0000_00AB, 5'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_req: req=%b we=%b rdy=%b required 1 1 0",
                     mem_req, mem_we, req_ready);
        end
        n_cmp++;
        if (mem_be !== 4'b1000) begin
            n_bad++;
            $display("FAIL sb_be: got %b required 1000", mem_be);
        end
        n_cmp++;
        if (mem_wdata !== 32'hABAB_ABAB) begin
            n_bad++;
            $display("FAIL sb_wdata: got %h required ababab ab", mem_wdata);
        end
        n_cmp++;
        if (mem_addr !== 32'h0000_0100) begin
            n_bad++;
            $display("FAIL sb_addr: got %h required 00000100", mem_addr);
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || wb_valid !== 1'b0 || exc_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_done: done=%b wb=%b exc=%b required 1 0 0",
                     done, wb_valid, exc_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_after: done=%b rdy=%b required 0 1", done, req_ready);
        end
    endtask

    logic [2:0]  ld_f3  [8] = '{F3_B, F3_BU, F3_HU, F3_H, F3_B, F3_W, F3_B, F3_HU};
    logic [31:0] ld_a   [8] = '{32'h102, 32'h102, 32'h102, 32'h102,
                                32'h101, 32'h100, 32'h100, 32'h100};
    logic [31:0] ld_rd  [8] = '{32'h00F0_0000, 32'h00F0_0000, 32'h00F0_0000,
                                32'h80F0_0000, 32'h0000_7F00, 32'h1234_5678,
                                32'h0000_0080, 32'hFFFF_8001};
    logic [31:0] ld_exp [8] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_00F0,
                                32'hFFFF_80F0, 32'h0000_007F, 32'h1234_5678,
                                32'hFFFF_FF80, 32'h0000_8001};

    task automatic test_load_extract();
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, ld_f3[i], ld_a[i], 32'h0, 5'd1);
            mem_ack   = 1'b1;
            mem_rdata = ld_rd[i];
            @(posedge clk);
            #1 mem_ack = 1'b0;
            mem_rdata = 32'h0;
            @(negedge clk);
            n_cmp++;
            if (wb_valid !== 1'b1 || wb_data !== ld_exp[i]) begin
                n_bad++;
                $display("FAIL load_%0d: wb=%b data=%h required 1 %h",
                         i, wb_valid, wb_data, ld_exp[i]);
            end
        end
    endtask

    task automatic test_lw_delay();
        int bad_cyc;
        bad_cyc = 0;
        drive_req(1'b1, F3_W, 32'h0000_0200, 32'h0, 5'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== 32'h200 || done !== 1'b0)
                bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc != 0) begin
            n_bad++;
            $display("FAIL lw_hold: %0d unstable cycles required 0", bad_cyc);
        end
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL lw_wb: wb=%b rd=%0d data=%h required 1 5 deadbeef",
                     wb_valid, wb_rd, wb_data);
        end
        @(negedge clk);
        n_cmp++;
        if (wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_pulse: wb=%b required 0", wb_valid);
        end
    endtask

    task automatic test_timeout(input logic ld, input logic [3:0] cause);
        int cnt;
        cnt = 0;
        drive_req(ld, F3_W, 32'h0000_0300, 32'h1, 5'd7);
        @(negedge clk);
        while (mem_req === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 255) begin
            n_bad++;
            $display("FAIL tmo_len: mem_req cycles %0d required 255", cnt);
        end
        n_cmp++;
        if (done !== 1'b1 || exc_valid !== 1'b1 || exc_cause !== cause ||
            wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_exc: done=%b exc=%b cause=%0d wb=%b required 1 1 %0d 0",
                     done, exc_valid, exc_cause, wb_valid, cause);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        drive_req(1'b1, F3_W, 32'h0000_0101, 32'h0, 5'd2);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || done !== 1'b1 || exc_valid !== 1'b1 ||
            exc_cause !== 4'd4 || wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_lw: req=%b done=%b exc=%b cause=%0d wb=%b required 0 1 1 4 0",
                     mem_req, done, exc_valid, exc_cause, wb_valid);
        end
        drive_req(1'b0, F3_H, 32'h0000_0101, 32'h1234, 5'd0);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || exc_valid !== 1'b1 || exc_cause !== 4'd6) begin
            n_bad++;
            $display("FAIL mis_sh: req=%b exc=%b cause=%0d required 0 1 6",
                     mem_req, exc_valid, exc_cause);
        end
`else
        drive_req(1'b1, F3_W, 32'h0000_0101, 32'h0, 5'd2);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'hF) begin
            n_bad++;
            $display("FAIL mis_lw_req: req=%b addr=%h be=%b required 1 00000100 1111",
                     mem_req, mem_addr, mem_be);
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || exc_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_lw_wb: wb=%b data=%h exc=%b required 1 cafef00d 0",
                     wb_valid, wb_data, exc_valid);
        end
        drive_req(1'b0, F3_H, 32'h0000_0101, 32'h0000_1234, 5'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_be !== 4'b0011 || mem_wdata !== 32'h1234_1234) begin
            n_bad++;
            $display("FAIL mis_sh: be=%b wd=%h required 0011 12341234",
                     mem_be, mem_wdata);
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_ack: done=%b wb=%b rdy=%b required 0 0 1",
                     done, wb_valid, req_ready);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:1] seen;
        seen = '0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_load   = 1'b0;
        req_store  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        req_wdata  = 32'h5555_AAAA;
        mem_ack    = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            seen[i] = done;
        end
        req_valid = 1'b0;
        req_store = 1'b0;
        mem_ack   = 1'b0;
        n_cmp++;
        if (seen !== 6'b010010) begin
            n_bad++;
            $display("FAIL b2b_done: pattern %b required 010010", seen);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, F3_W, 32'h0000_0400, 32'h0, 5'd3);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: req=%b required 1", mem_req);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: req=%b rdy=%b done=%b required 0 1 0",
                     mem_req, req_ready, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || wb_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_after: done=%b wb=%b required 0 0", done, wb_valid);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        test_reset();
        test_store_byte();
        test_load_extract();
        test_lw_delay();
        test_timeout(1'b1, 4'd5);
        test_timeout(1'b0, 4'd7);
        test_misalign();
        test_ack_ignored();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
